// File: rtl/ps2_keypad_mapper_pkg.sv
// ps2_keypad_pkg
// Shared definitions for the PS/2 -> ColecoVision keypad mapper:
//   - set-2 scancodes of every mapped key
//   - joystick bit indices of the merged joystick word
//   - direction encodings for the opposite-direction resolver
//   - decode_key(): {extended, code} -> 20-bit one-hot (zero if unmapped)
package ps2_keypad_pkg;

    localparam int NUM_KEYS = 20;

    // Joystick bit indices
    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_FIRE1  = 4;
    localparam int JB_FIRE2  = 5;
    localparam int JB_STAR   = 6;
    localparam int JB_HASH   = 7;
    localparam int JB_KEY0   = 8;
    localparam int JB_PURPLE = 18;
    localparam int JB_BLUE   = 19;

    // Extended scancodes (arrows)
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;

    // Non-extended scancodes
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_STAR   = 8'h7C;
    localparam logic [7:0] SC_HASH   = 8'h79;
    localparam logic [7:0] SC_PURPLE = 8'h1A;
    localparam logic [7:0] SC_BLUE   = 8'h22;

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;

    // Most recently pressed horizontal / vertical direction
    typedef enum logic { H_RIGHT = 1'b0, H_LEFT = 1'b1 } h_dir_e;
    typedef enum logic { V_DOWN  = 1'b0, V_UP   = 1'b1 } v_dir_e;

    // Extended and plain codes are decoded separately: plain 72/6B/74/75
    // are keypad digits, only their extended forms are arrows.
    function automatic logic [NUM_KEYS-1:0] decode_key(input logic ext,
                                                        input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_RIGHT: m[JB_RIGHT] = 1'b1;
                SC_LEFT:  m[JB_LEFT]  = 1'b1;
                SC_DOWN:  m[JB_DOWN]  = 1'b1;
                SC_UP:    m[JB_UP]    = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_LCTRL:      m[JB_FIRE1]  = 1'b1;
                SC_LALT:       m[JB_FIRE2]  = 1'b1;
                SC_STAR:       m[JB_STAR]   = 1'b1;
                SC_HASH:       m[JB_HASH]   = 1'b1;
                SC_PURPLE:     m[JB_PURPLE] = 1'b1;
                SC_BLUE:       m[JB_BLUE]   = 1'b1;
                SC_0, SC_KP0:  m[JB_KEY0 + 0] = 1'b1;
                SC_1, SC_KP1:  m[JB_KEY0 + 1] = 1'b1;
                SC_2, SC_KP2:  m[JB_KEY0 + 2] = 1'b1;
                SC_3, SC_KP3:  m[JB_KEY0 + 3] = 1'b1;
                SC_4, SC_KP4:  m[JB_KEY0 + 4] = 1'b1;
                SC_5, SC_KP5:  m[JB_KEY0 + 5] = 1'b1;
                SC_6, SC_KP6:  m[JB_KEY0 + 6] = 1'b1;
                SC_7, SC_KP7:  m[JB_KEY0 + 7] = 1'b1;
                SC_8, SC_KP8:  m[JB_KEY0 + 8] = 1'b1;
                SC_9, SC_KP9:  m[JB_KEY0 + 9] = 1'b1;
                default:       m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_keypad_mapper_key_hold_timer.sv
// key_hold_timer
// Physical-state flag plus minimum-hold counter for one mapped key.
// Ports:
//   clk_sys, reset  clock, asynchronous active-high reset
//   clr_i           synchronous clear of flag and counter (keyboard disabled)
//   press_i         press event: flag set, counter loaded with HOLD_TICKS
//   release_i       release event: flag cleared, counter keeps running
//   tick_i          hold tick: nonzero counter decrements
//   active_o        flag | (counter != 0)
module key_hold_timer #(
    parameter int HOLD_TICKS = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr_i,
    input  logic press_i,
    input  logic release_i,
    input  logic tick_i,
    output logic active_o
);

    logic       phys_q, phys_d;
    logic [4:0] hold_q, hold_d;

    always_comb begin
        phys_d = phys_q;
        hold_d = hold_q;
        if (clr_i) begin
            phys_d = 1'b0;
            hold_d = '0;
        end else if (press_i) begin
            // A reload beats a coincident tick so a tap never loses a tick.
            phys_d = 1'b1;
            hold_d = 5'(HOLD_TICKS);
        end else begin
            if (release_i) begin
                phys_d = 1'b0;
            end
            if (tick_i && hold_q != '0) begin
                hold_d = hold_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            phys_q <= 1'b0;
            hold_q <= '0;
        end else begin
            phys_q <= phys_d;
            hold_q <= hold_d;
        end
    end

    assign active_o = phys_q | (hold_q != '0);

endmodule

// File: rtl/ps2_keypad_mapper.sv
// ps2_keypad_mapper
// Turns PS/2 key events into ColecoVision joystick/keypad bits, stretches
// short taps, resolves opposite directions (last pressed wins) and ORs the
// result into the host joystick word.
// Ports:
//   clk_sys      system clock
//   reset        asynchronous active-high reset
//   ps2_key      [7:0] code, [8] extended, [9] pressed, [10] event toggle
//   kbd_en       1 = mapping active, 0 = state flushed, joy_i passed through
//   joy_i        host joystick word
//   joy_o        registered merged joystick word
//   kbd_state_o  registered effective keyboard bits
module ps2_keypad_mapper
    import ps2_keypad_pkg::*;
#(
    parameter int PRESCALE   = 21477,
    parameter int HOLD_TICKS = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        kbd_en,
    input  logic [31:0] joy_i,
    output logic [31:0] joy_o,
    output logic [19:0] kbd_state_o
);

    localparam int PW = $clog2(PRESCALE);

    // Event capture. The valid flags make sure the first real sample after
    // reset only seeds the previous-toggle register.
    logic [10:0] key_q;
    logic        key_valid_q;
    logic        tog_prev_q;
    logic        prev_valid_q;
    logic        evt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            tog_prev_q   <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            key_q        <= ps2_key;
            key_valid_q  <= 1'b1;
            tog_prev_q   <= key_q[10];
            prev_valid_q <= key_valid_q;
        end
    end

    assign evt = key_valid_q && prev_valid_q && (key_q[10] != tog_prev_q);

    logic [NUM_KEYS-1:0] hit, press_vec, rel_vec, eff;

    assign hit       = decode_key(key_q[8], key_q[7:0]);
    assign press_vec = hit & {NUM_KEYS{evt &  key_q[9]}};
    assign rel_vec   = hit & {NUM_KEYS{evt & ~key_q[9]}};

    // Hold tick prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_hold_timer #(
                .HOLD_TICKS (HOLD_TICKS)
            ) u_timer (
                .clk_sys   (clk_sys),
                .reset     (reset),
                .clr_i     (~kbd_en),
                .press_i   (press_vec[gi]),
                .release_i (rel_vec[gi]),
                .tick_i    (tick),
                .active_o  (eff[gi])
            );
        end
    endgenerate

    // Most recent direction on each axis
    h_dir_e last_h_q, last_h_d;
    v_dir_e last_v_q, last_v_d;

    always_comb begin
        last_h_d = last_h_q;
        last_v_d = last_v_q;
        if (!kbd_en) begin
            last_h_d = H_RIGHT;
            last_v_d = V_DOWN;
        end else begin
            if (press_vec[JB_RIGHT])     last_h_d = H_RIGHT;
            else if (press_vec[JB_LEFT]) last_h_d = H_LEFT;
            if (press_vec[JB_DOWN])      last_v_d = V_DOWN;
            else if (press_vec[JB_UP])   last_v_d = V_UP;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_h_q <= H_RIGHT;
            last_v_q <= V_DOWN;
        end else begin
            last_h_q <= last_h_d;
            last_v_q <= last_v_d;
        end
    end

    // Opposite-direction resolution and output assembly
    logic [19:0] kbd_d;
    logic [31:0] joy_d;

    always_comb begin
        kbd_d = eff;
        if (eff[JB_RIGHT] && eff[JB_LEFT]) begin
            if (last_h_q == H_LEFT) kbd_d[JB_RIGHT] = 1'b0;
            else                    kbd_d[JB_LEFT]  = 1'b0;
        end
        if (eff[JB_DOWN] && eff[JB_UP]) begin
            if (last_v_q == V_UP) kbd_d[JB_DOWN] = 1'b0;
            else                  kbd_d[JB_UP]   = 1'b0;
        end
        if (!kbd_en) begin
            kbd_d = '0;
        end
        joy_d = {joy_i[31:20], joy_i[19:0] | kbd_d};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            kbd_state_o <= '0;
            joy_o       <= '0;
        end else begin
            kbd_state_o <= kbd_d;
            joy_o       <= joy_d;
        end
    end

endmodule

// File: tb/tb_ps2_keypad_mapper.sv
module tb_ps2_keypad_mapper;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        kbd_en;
    logic [31:0] joy_i;
    logic [31:0] joy_o;
    logic [19:0] kbd_state_o;

    int tests  = 0;
    int failed = 0;
    logic tog = 1'b0;

    ps2_keypad_mapper #(
        .PRESCALE   (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .kbd_en      (kbd_en),
        .joy_i       (joy_i),
        .joy_o       (joy_o),
        .kbd_state_o (kbd_state_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        ext;
        logic [7:0]  code;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[21];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{1'b1, 8'h74, 20'h00001, "E74_right"};
        vecs[1]  = '{1'b1, 8'h6B, 20'h00002, "E6B_left"};
        vecs[2]  = '{1'b1, 8'h72, 20'h00004, "E72_down"};
        vecs[3]  = '{1'b1, 8'h75, 20'h00008, "E75_up"};
        vecs[4]  = '{1'b0, 8'h14, 20'h00010, "14_fire1"};
        vecs[5]  = '{1'b0, 8'h11, 20'h00020, "11_fire2"};
        vecs[6]  = '{1'b0, 8'h7C, 20'h00040, "7C_star"};
        vecs[7]  = '{1'b0, 8'h79, 20'h00080, "79_hash"};
        vecs[8]  = '{1'b0, 8'h45, 20'h00100, "45_key0"};
        vecs[9]  = '{1'b0, 8'h16, 20'h00200, "16_key1"};
        vecs[10] = '{1'b0, 8'h3E, 20'h10000, "3E_key8"};
        vecs[11] = '{1'b0, 8'h46, 20'h20000, "46_key9"};
        vecs[12] = '{1'b0, 8'h70, 20'h00100, "70_kp0"};
        vecs[13] = '{1'b0, 8'h72, 20'h00400, "72_kp2"};
        vecs[14] = '{1'b0, 8'h6B, 20'h01000, "6B_kp4"};
        vecs[15] = '{1'b0, 8'h75, 20'h10000, "75_kp8"};
        vecs[16] = '{1'b0, 8'h7D, 20'h20000, "7D_kp9"};
        vecs[17] = '{1'b0, 8'h1A, 20'h40000, "1A_purple"};
        vecs[18] = '{1'b0, 8'h22, 20'h80000, "22_blue"};
        vecs[19] = '{1'b1, 8'h14, 20'h00000, "E14_unmapped"};
        vecs[20] = '{1'b0, 8'h1C, 20'h00000, "1C_unmapped"};

        reset   = 1'b1;
        ps2_key = '0;
        kbd_en  = 1'b1;
        joy_i   = '0;
        cyc(3);
        chk("reset_joy", joy_o, 32'h0);
        chk("reset_kbd", {12'h0, kbd_state_o}, 32'h0);
        reset = 1'b0;
        cyc(4);
        chk("idle_joy", joy_o, 32'h0);

        // Table: single key press, then release and hold expiry
        for (int i = 0; i < 21; i++) begin
            send(1'b1, vecs[i].ext, vecs[i].code);
            cyc(3);
            chk({vecs[i].name, "_kbd"}, {12'h0, kbd_state_o}, {12'h0, vecs[i].exp});
            chk({vecs[i].name, "_joy"}, joy_o, {12'h0, vecs[i].exp});
            send(1'b0, vecs[i].ext, vecs[i].code);
            cyc(20);
            chk({vecs[i].name, "_expired"}, {12'h0, kbd_state_o}, 32'h0);
        end

        // Tap of key 1: latency and stretched duration
        send(1'b1, 1'b0, 8'h16);
        cyc(1);
        send(1'b0, 1'b0, 8'h16);
        cyc(1);
        chk("tap_n2", {31'h0, joy_o[9]}, 32'h0);
        cyc(1);
        chk("tap_n3", {31'h0, joy_o[9]}, 32'h1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (joy_o[9]) cnt++;
            else break;
            cyc(1);
        end
        chk("tap_min8", {31'h0, cnt >= 8}, 32'h1);
        chk("tap_max14", {31'h0, cnt <= 14}, 32'h1);
        chk("tap_cleared", {31'h0, joy_o[9]}, 32'h0);

        // Horizontal SOCD
        send(1'b1, 1'b1, 8'h6B);
        cyc(3);
        chk("socd_left", {30'h0, joy_o[1:0]}, 32'h2);
        send(1'b1, 1'b1, 8'h74);
        cyc(3);
        chk("socd_right_wins", {30'h0, joy_o[1:0]}, 32'h1);
        send(1'b0, 1'b1, 8'h74);
        cyc(20);
        chk("socd_left_back", {30'h0, joy_o[1:0]}, 32'h2);
        send(1'b0, 1'b1, 8'h6B);
        cyc(20);
        chk("socd_h_clear", {30'h0, joy_o[1:0]}, 32'h0);

        // Vertical SOCD
        send(1'b1, 1'b1, 8'h75);
        cyc(3);
        send(1'b1, 1'b1, 8'h72);
        cyc(3);
        chk("socd_down_wins", {28'h0, joy_o[3:0]}, 32'h4);
        send(1'b1, 1'b1, 8'h75);
        cyc(3);
        chk("socd_up_wins", {28'h0, joy_o[3:0]}, 32'h8);
        send(1'b0, 1'b1, 8'h75);
        cyc(1);
        send(1'b0, 1'b1, 8'h72);
        cyc(20);
        chk("socd_v_clear", {28'h0, joy_o[3:0]}, 32'h0);

        // Pass-through of joy_i and merge
        joy_i = 32'hFFF0_0001;
        cyc(1);
        chk("pass_joy_i", joy_o, 32'hFFF0_0001);
        send(1'b1, 1'b0, 8'h1A);
        cyc(3);
        chk("merge_purple", joy_o, 32'hFFF4_0001);
        send(1'b0, 1'b0, 8'h1A);
        cyc(20);
        chk("merge_released", joy_o, 32'hFFF0_0001);
        joy_i = '0;
        cyc(2);

        // Reset mid-hold, then first sample with toggle=1 is not an event
        send(1'b1, 1'b0, 8'h14);
        cyc(3);
        chk("fire1_before_reset", {31'h0, joy_o[4]}, 32'h1);
        reset = 1'b1;
        #2;
        chk("async_reset_joy", joy_o, 32'h0);
        chk("async_reset_kbd", {12'h0, kbd_state_o}, 32'h0);
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
        cyc(2);
        reset = 1'b0;
        cyc(8);
        chk("first_sample_no_event", {12'h0, kbd_state_o}, 32'h0);

        // kbd_en flush while key 0 stays physically held
        send(1'b1, 1'b0, 8'h45);
        cyc(2);
        chk("lat_key0_n2", {31'h0, joy_o[8]}, 32'h0);
        cyc(1);
        chk("lat_key0_n3", {31'h0, joy_o[8]}, 32'h1);
        cyc(5);
        kbd_en = 1'b0;
        cyc(1);
        kbd_en = 1'b1;
        chk("flush_key0", {31'h0, joy_o[8]}, 32'h0);
        cyc(20);
        chk("flush_stays", {31'h0, joy_o[8]}, 32'h0);
        send(1'b1, 1'b0, 8'h45);
        cyc(3);
        chk("repress_key0", {31'h0, joy_o[8]}, 32'h1);
        send(1'b0, 1'b0, 8'h45);
        cyc(20);
        chk("final_clear", {12'h0, kbd_state_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ps2_keypad_mapper.md
Name: ps2_keypad_mapper

Overview:
- Converts host PS/2 key events (the `ps2_key` toggle interface) into ColecoVision joystick/keypad bits.
- ORs them into the host joystick word that feeds the console controller logic. Sits directly upstream of the controller mux: its `joy_o` drives `joystick_0`.
- Adds a minimum-hold stretch so short taps survive BIOS keypad polling.
- Resolves simultaneous opposite directions: last pressed wins.

Parameters:
- PRESCALE, 21477, clk_sys cycles per hold tick (1 ms at 21.477 MHz); must be >= 2.
- HOLD_TICKS, 16, minimum asserted duration of a tapped key, in ticks; 1..31.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event.
- kbd_en  in  1  1 = keyboard mapping active; 0 = flush and pass through.
- joy_i  in  32  host joystick word.
- joy_o  out  32  merged joystick word; registered.
- kbd_state_o  out  20  effective keyboard bits [19:0], after hold and SOCD; registered.

Behaviour:
- Bit map (joy bit <- set-2 code, E = extended):
  - 0 right <- E74; 1 left <- E6B; 2 down <- E72; 3 up <- E75.
  - 4 fire1 <- 14 (LCtrl); 5 fire2 <- 11 (LAlt).
  - 6 '*' <- 7C; 7 '#' <- 79.
  - 8..17 keys 0..9 <- main row 45,16,1E,26,25,2E,36,3D,3E,46, or keypad 70,69,72,7A,6B,73,74,6C,75,7D (non-extended).
  - 18 purple <- 1A; 19 blue <- 22.
  - The extended flag must match exactly: non-extended 72/6B/74/75 are keypad digits, not arrows. Unmapped codes are ignored.
- Event capture: `ps2_key` is sampled into a register each cycle. An event is detected when sampled bit 10 differs from the previous sample.
  - The first sample after reset only initialises the previous-toggle register; it never produces an event.
- Per mapped bit:
  - `phys` flag and a 5-bit `hold` counter.
  - Press: phys <= 1, hold <= HOLD_TICKS.
  - Release: phys <= 0; hold keeps running.
  - Effective bit = phys | (hold != 0).
- Tick: free-running counter 0..PRESCALE-1; tick pulse for one cycle at wrap. On tick, every nonzero hold decrements.
  - Press and tick in the same cycle: the load wins.
- Minimum assertion after a tap is >= (HOLD_TICKS-1)*PRESCALE cycles and <= HOLD_TICKS*PRESCALE + 2 cycles.
- Repeat presses (typematic) reload hold. A release without a prior press is harmless.
- SOCD:
  - `last_h` register: set to right/left on each right/left press. `last_v` does the same for down/up.
  - If both effective left and right are 1, only the `last_h` one is output. Same rule for up/down.
  - A direction is never suppressed when its opposite is inactive.
- Latency:
  - Toggle change visible on `ps2_key` at edge N.
  - Captured at N+1, phys/hold updated at N+2.
  - `joy_o` and `kbd_state_o` updated at N+3.
- Output assembly: joy_o[19:0] = joy_i[19:0] | kbd_state; joy_o[31:20] = joy_i[31:20]. `joy_i` goes through the same single output register stage.
- kbd_en = 0: all phys, hold, last_h and last_v are cleared synchronously every cycle, and kbd_state = 0. Re-enabling starts from empty state, and held physical keys are not asserted until a new press event.
- Reset (asynchronous; also mid-hold):
  - joy_o = 0, kbd_state_o = 0.
  - All phys, hold, prescaler, last_h and last_v = 0; previous-toggle register uninitialised-flag set.

Decomposition:
- Package `ps2_keypad_pkg`:
  - Scancode localparams (SC_UP, SC_KP0, ...).
  - Joystick bit-index localparams (JB_RIGHT=0 ... JB_BLUE=19).
  - Decode function: {ext, code} -> 20-bit one-hot, or zero.
- Sub-module `key_hold_timer`: phys + hold counter for one bit, with inputs press, release, tick, clr. Instantiated 20 times by generate.
- Top level holds capture, prescaler, SOCD and the output register.

Test Plan:
1. PRESCALE=4, HOLD_TICKS=3. Press then release 16 (key 1) 1 cycle apart -> joy_o[9] = 1 from N+3 and stays 1 for >= 8 cycles; 0 within 14 cycles of press.
2. Hold E6B, then press E74 with both held -> joy_o[1:0] = 2'b01. Release E74 and let its hold expire -> joy_o[1:0] = 2'b10.
3. Non-extended 75 vs extended E75 -> the first sets joy_o[16] (key 8) only; the second sets joy_o[3] only.
4. joy_i = 32'hFFF0_0001, no keys -> joy_o = 32'hFFF0_0001. Press 1A -> joy_o = 32'hFFF4_0001.
5. Press 14 (fire1), assert reset mid-hold -> joy_o = 0 the same cycle. After reset release, the first `ps2_key` sample with bit 10 = 1 creates no event.
6. Hold 45, drop kbd_en for 1 cycle -> joy_o[8] = 0 after 1 cycle and stays 0 while 45 is still physically held. A new 45 press event restores it.
